// File: rtl/pool_pkg.sv
// -----------------------------------------------------------------------------
// pool_pkg
// Shared types and constants for the 2x2 pooling window generator.
//   PIX_W_DEF       default pixel width in bits
//   IMG_WIDTH_DEF   default pixels per row
//   IMG_HEIGHT_DEF  default rows per frame
//   pixel_t         one pixel at the default width
//   window_t        one 2x2 window {p00, p01, p10, p11}
//   pos_w()         counter width for a position range 0..n-1 (at least 1 bit)
// -----------------------------------------------------------------------------
package pool_pkg;

  localparam int PIX_W_DEF      = 8;
  localparam int IMG_WIDTH_DEF  = 8;
  localparam int IMG_HEIGHT_DEF = 8;

  typedef logic [PIX_W_DEF-1:0] pixel_t;

  typedef struct packed {
    pixel_t p00;
    pixel_t p01;
    pixel_t p10;
    pixel_t p11;
  } window_t;

  // Width needed to count 0..n-1; a range of 1 or 2 still needs one bit.
  function automatic int pos_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int COL_W_DEF = pos_w(IMG_WIDTH_DEF);
  localparam int ROW_W_DEF = pos_w(IMG_HEIGHT_DEF);

endpackage

// File: rtl/pool_line_buffer.sv
// -----------------------------------------------------------------------------
// pool_line_buffer
// One image row of pixel storage used to pair the even row with the odd row
// that follows it.
//   clk        clock; writes on the rising edge
//   i_we       write enable
//   i_waddr    write column
//   i_wdata    pixel written
//   i_raddr_a  read column for port A (left pixel of a window, col-1)
//   i_raddr_b  read column for port B (right pixel of a window, col)
//   o_rdata_a  port A data, combinational
//   o_rdata_b  port B data, combinational
// Contents are never reset: every location is written on an even row before
// the following odd row reads it.
// -----------------------------------------------------------------------------
module pool_line_buffer #(
  parameter int PIX_W     = pool_pkg::PIX_W_DEF,
  parameter int IMG_WIDTH = pool_pkg::IMG_WIDTH_DEF,
  localparam int ADDR_W   = pool_pkg::pos_w(IMG_WIDTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [PIX_W-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr_a,
  input  logic [ADDR_W-1:0] i_raddr_b,
  output logic [PIX_W-1:0]  o_rdata_a,
  output logic [PIX_W-1:0]  o_rdata_b
);

  // Sized to the full address space so every address value indexes a real
  // entry even when IMG_WIDTH is not a power of two; the extra entries are
  // simply never written or read.
  localparam int DEPTH = 1 << ADDR_W;

  logic [PIX_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/pool2x2_window_gen.sv
// -----------------------------------------------------------------------------
// pool2x2_window_gen
// Turns a raster-order pixel stream into non-overlapping stride-2 2x2 windows
// for the max-pooling comparator. Even rows are parked in a one-row line
// buffer; on odd rows the even-column pixel is held and the odd-column pixel
// completes a window, which is registered one cycle after it is accepted.
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   in_pixel valid this cycle
//   in_ready   block can accept a pixel (!out_valid || out_ready)
//   in_pixel   raster-order pixel
//   out_valid  window outputs valid
//   out_ready  downstream accepts the window
//   pixel_00   top-left     (row 2r,   col 2c)
//   pixel_01   top-right    (row 2r,   col 2c+1)
//   pixel_10   bottom-left  (row 2r+1, col 2c)
//   pixel_11   bottom-right (row 2r+1, col 2c+1)
//   out_last   window is the last of the frame (qualified by out_valid)
//
// Build option POOL_SOF_EN adds:
//   in_sof     accepted beat is pixel (0,0) of a frame
//   sync_err   sticky: an in_sof beat arrived away from (0,0)
// Without it the position counters free-run purely on accepted beats.
// -----------------------------------------------------------------------------
module pool2x2_window_gen
  import pool_pkg::*;
#(
  parameter int PIX_W      = PIX_W_DEF,
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pixel,
`ifdef POOL_SOF_EN
  input  logic             in_sof,
  output logic             sync_err,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] pixel_00,
  output logic [PIX_W-1:0] pixel_01,
  output logic [PIX_W-1:0] pixel_10,
  output logic [PIX_W-1:0] pixel_11,
  output logic             out_last
);

  localparam int COL_W = pos_w(IMG_WIDTH);
  localparam int ROW_W = pos_w(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_HEIGHT - 1);

  // Position of the next pixel expected in the raster.
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  // Even-column pixel of the current odd row, waiting for its right neighbour.
  logic [PIX_W-1:0] r_held;

  logic             r_out_valid;
  logic             r_out_last;
  logic [PIX_W-1:0] r_p00;
  logic [PIX_W-1:0] r_p01;
  logic [PIX_W-1:0] r_p10;
  logic [PIX_W-1:0] r_p11;

  logic             w_accept;
  logic [COL_W-1:0] w_col_eff;
  logic [ROW_W-1:0] w_row_eff;
  logic [COL_W-1:0] w_col_prev;
  logic             w_odd_row;
  logic             w_odd_col;
  logic             w_win_done;
  logic             w_frame_end;
  logic             w_lb_we;
  logic [PIX_W-1:0] w_lb_left;
  logic [PIX_W-1:0] w_lb_right;

  // A window can only be overwritten once downstream has taken it, so input
  // is stalled exactly while a window is stuck on the output.
  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

`ifdef POOL_SOF_EN
  logic w_resync;
  logic r_sync_err;

  // A start-of-frame beat is treated as pixel (0,0) regardless of where the
  // counters were. Because it lands on an even row, any half-built window on
  // the old odd row can never complete and is dropped implicitly.
  assign w_resync  = w_accept && in_sof;
  assign w_col_eff = w_resync ? '0 : r_col;
  assign w_row_eff = w_resync ? '0 : r_row;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_err <= 1'b0;
    end else if (w_resync && ((r_col != '0) || (r_row != '0))) begin
      r_sync_err <= 1'b1;
    end
  end

  assign sync_err = r_sync_err;
`else
  assign w_col_eff = r_col;
  assign w_row_eff = r_row;
`endif

  assign w_odd_row   = w_row_eff[0];
  assign w_odd_col   = w_col_eff[0];
  // Only used when w_odd_col is set, so col-1 never underflows in practice.
  assign w_col_prev  = w_col_eff - 1'b1;
  assign w_win_done  = w_accept && w_odd_row && w_odd_col;
  assign w_frame_end = (w_row_eff == ROW_MAX) && (w_col_eff == COL_MAX);
  assign w_lb_we     = w_accept && !w_odd_row;

  pool_line_buffer #(
    .PIX_W     (PIX_W),
    .IMG_WIDTH (IMG_WIDTH)
  ) u_line_buffer (
    .clk       (clk),
    .i_we      (w_lb_we),
    .i_waddr   (w_col_eff),
    .i_wdata   (in_pixel),
    .i_raddr_a (w_col_prev),
    .i_raddr_b (w_col_eff),
    .o_rdata_a (w_lb_left),
    .o_rdata_b (w_lb_right)
  );

  // Raster position counters; only accepted beats move them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_col_eff == COL_MAX) begin
        r_col <= '0;
        r_row <= (w_row_eff == ROW_MAX) ? '0 : w_row_eff + 1'b1;
      end else begin
        r_col <= w_col_eff + 1'b1;
        r_row <= w_row_eff;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_held <= '0;
    end else if (w_accept && w_odd_row && !w_odd_col) begin
      r_held <= in_pixel;
    end
  end

  // Output register. A completing window always loads (the input could only
  // be accepted if the previous window was free or being taken). Otherwise a
  // taken window simply drops valid; pixel data is left as-is since it is
  // only meaningful while out_valid is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_p00       <= '0;
      r_p01       <= '0;
      r_p10       <= '0;
      r_p11       <= '0;
    end else if (w_win_done) begin
      r_out_valid <= 1'b1;
      r_out_last  <= w_frame_end;
      r_p00       <= w_lb_left;
      r_p01       <= w_lb_right;
      r_p10       <= r_held;
      r_p11       <= in_pixel;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign pixel_00  = r_p00;
  assign pixel_01  = r_p01;
  assign pixel_10  = r_p10;
  assign pixel_11  = r_p11;

endmodule

// File: tb/tb_pool2x2_window_gen.sv
// -----------------------------------------------------------------------------
// tb_pool2x2_window_gen
// Directed bench for pool2x2_window_gen on a 4x4 image. Build with
// POOL_SOF_EN defined to also exercise the start-of-frame resync.
// -----------------------------------------------------------------------------
module tb_pool2x2_window_gen;

  localparam int PW = 8;
  localparam int W  = 4;
  localparam int H  = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_pixel;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] pixel_00;
  logic [PW-1:0] pixel_01;
  logic [PW-1:0] pixel_10;
  logic [PW-1:0] pixel_11;
  logic          out_last;
`ifdef POOL_SOF_EN
  logic          in_sof;
  logic          sync_err;
`endif

  pool2x2_window_gen #(
    .PIX_W      (PW),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pixel  (in_pixel),
`ifdef POOL_SOF_EN
    .in_sof    (in_sof),
    .sync_err  (sync_err),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pixel_00  (pixel_00),
    .pixel_01  (pixel_01),
    .pixel_10  (pixel_10),
    .pixel_11  (pixel_11),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record per clock: inputs driven for the cycle, in_ready expected
  // before the edge, outputs expected just after it.
  typedef struct {
    logic          vld;
    logic          sof;
    logic [PW-1:0] pix;
    logic          ordy;
    logic          exp_rdy;
    logic          exp_ov;
    logic [PW-1:0] e00;
    logic [PW-1:0] e01;
    logic [PW-1:0] e10;
    logic [PW-1:0] e11;
    logic          exp_last;
  } vec_t;

  vec_t vq[$];
  int   n_checks;
  int   n_errors;
  int   n_windows;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input logic vld, input logic sof, input logic [PW-1:0] pix,
                         input logic ordy, input logic exp_rdy, input logic exp_ov,
                         input logic [PW-1:0] e00, input logic [PW-1:0] e01,
                         input logic [PW-1:0] e10, input logic [PW-1:0] e11,
                         input logic exp_last);
    vec_t v;
    v.vld = vld; v.sof = sof; v.pix = pix; v.ordy = ordy;
    v.exp_rdy = exp_rdy; v.exp_ov = exp_ov;
    v.e00 = e00; v.e01 = e01; v.e10 = e10; v.e11 = e11;
    v.exp_last = exp_last;
    vq.push_back(v);
  endtask

  // Beats k_lo..k_hi of a 4x4 frame whose pixel k has value base+k. The
  // window offsets below are the hand-worked 2x2 blocks of a 4x4 raster.
  task automatic add_frame(input int base, input int k_lo, input int k_hi, input logic sof_first);
    for (int k = k_lo; k <= k_hi; k++) begin
      logic [PW-1:0] p;
      logic          s;
      p = PW'(base + k);
      s = sof_first && (k == k_lo);
      case (k)
        5:  add_vec(1, s, p, 1, 1, 1, PW'(base+0),  PW'(base+1),  PW'(base+4),  PW'(base+5),  0);
        7:  add_vec(1, s, p, 1, 1, 1, PW'(base+2),  PW'(base+3),  PW'(base+6),  PW'(base+7),  0);
        13: add_vec(1, s, p, 1, 1, 1, PW'(base+8),  PW'(base+9),  PW'(base+12), PW'(base+13), 0);
        15: add_vec(1, s, p, 1, 1, 1, PW'(base+10), PW'(base+11), PW'(base+14), PW'(base+15), 1);
        default: add_vec(1, s, p, 1, 1, 0, 0, 0, 0, 0, 0);
      endcase
    end
  endtask

  task automatic add_idle();
    add_vec(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
  endtask

  // Called just after a rising edge; leaves the bench just after the last edge.
  task automatic run_vectors(input string tag);
    for (int i = 0; i < vq.size(); i++) begin
      in_valid  = vq[i].vld;
      in_pixel  = vq[i].pix;
      out_ready = vq[i].ordy;
`ifdef POOL_SOF_EN
      in_sof    = vq[i].sof;
`endif
      #1;
      chk($sformatf("%s[%0d] in_ready", tag, i), {31'd0, in_ready}, {31'd0, vq[i].exp_rdy});
      @(posedge clk);
      #1;
      chk($sformatf("%s[%0d] out_valid", tag, i), {31'd0, out_valid}, {31'd0, vq[i].exp_ov});
      if (vq[i].exp_ov) begin
        n_windows++;
        chk($sformatf("%s[%0d] window", tag, i),
            {pixel_00, pixel_01, pixel_10, pixel_11},
            {vq[i].e00, vq[i].e01, vq[i].e10, vq[i].e11});
        chk($sformatf("%s[%0d] out_last", tag, i), {31'd0, out_last}, {31'd0, vq[i].exp_last});
        $display("%s win: %02h %02h %02h %02h last=%0b", tag,
                 pixel_00, pixel_01, pixel_10, pixel_11, out_last);
      end
    end
    vq.delete();
    in_valid = 1'b0;
`ifdef POOL_SOF_EN
    in_sof   = 1'b0;
`endif
  endtask

  // Holds reset across two edges and checks the outputs while it is asserted.
  task automatic do_reset(input string tag);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
`ifdef POOL_SOF_EN
    in_sof   = 1'b0;
`endif
    #1;
    chk({tag, " rst out_valid"}, {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk({tag, " rst out_valid held"}, {31'd0, out_valid}, 32'd0);
    chk({tag, " rst out_last"}, {31'd0, out_last}, 32'd0);
    chk({tag, " rst pixels"}, {pixel_00, pixel_01, pixel_10, pixel_11}, 32'd0);
    chk({tag, " rst in_ready"}, {31'd0, in_ready}, 32'd1);
`ifdef POOL_SOF_EN
    chk({tag, " rst sync_err"}, {31'd0, sync_err}, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    $display("%s reset done", tag);
  endtask

  initial begin
    vec_t sv;
    n_checks  = 0;
    n_errors  = 0;
    n_windows = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_pixel  = '0;
    out_ready = 1'b1;
`ifdef POOL_SOF_EN
    in_sof    = 1'b0;
`endif
    @(posedge clk);
    #1;
    do_reset("init");

    // Plain frame, no stalls.
    add_frame(0, 0, 15, 0);
    add_idle();
    run_vectors("nostall");

    // Three stall cycles right after the first window; pixel 6 is offered
    // throughout and must be taken only once the window is released.
    add_frame(0, 0, 15, 0);
    sv.vld = 1; sv.sof = 0; sv.pix = 8'd6; sv.ordy = 0; sv.exp_rdy = 0; sv.exp_ov = 1;
    sv.e00 = 8'd0; sv.e01 = 8'd1; sv.e10 = 8'd4; sv.e11 = 8'd5; sv.exp_last = 0;
    for (int s = 0; s < 3; s++) vq.insert(6, sv);
    add_idle();
    run_vectors("stall");

    // Extreme values, then reset after pixel 9 of the frame.
    add_vec(1, 0, 8'hFF, 1, 1, 0, 0, 0, 0, 0, 0);
    add_vec(1, 0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 0);
    add_vec(1, 0, 8'hAA, 1, 1, 0, 0, 0, 0, 0, 0);
    add_vec(1, 0, 8'h55, 1, 1, 0, 0, 0, 0, 0, 0);
    add_vec(1, 0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 0);
    add_vec(1, 0, 8'hFF, 1, 1, 1, 8'hFF, 8'h00, 8'h00, 8'hFF, 0);
    add_vec(1, 0, 8'h55, 1, 1, 0, 0, 0, 0, 0, 0);
    add_vec(1, 0, 8'hAA, 1, 1, 1, 8'hAA, 8'h55, 8'h55, 8'hAA, 0);
    add_vec(1, 0, 8'd8,  1, 1, 0, 0, 0, 0, 0, 0);
    add_vec(1, 0, 8'd9,  1, 1, 0, 0, 0, 0, 0, 0);
    run_vectors("extreme");
    do_reset("midframe");
    add_frame(100, 0, 15, 0);
    add_idle();
    run_vectors("after_rst");

    // Two frames back to back with no gap.
    add_frame(0, 0, 15, 0);
    add_frame(16, 0, 15, 0);
    add_idle();
    run_vectors("b2b");

`ifdef POOL_SOF_EN
    // Start-of-frame on pixel 6 restarts the raster at that pixel.
    do_reset("sof");
    add_frame(0, 0, 5, 0);
    add_frame(6, 0, 15, 1);
    add_idle();
    run_vectors("sof");
    chk("sof sync_err", {31'd0, sync_err}, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pool2x2_window_gen.md
Name: pool2x2_window_gen

Overview:
Upstream stage of the 2x2 max-pooling block. Accepts a raster-scan pixel stream (one pixel per beat, valid/ready). Buffers one image row internally. Emits non-overlapping, stride-2, 2x2 windows as pixel_00/01/10/11, ready to drive the pooling comparator directly. One window is produced per 2x2 block, so a frame yields (IMG_WIDTH/2)*(IMG_HEIGHT/2) windows.

Parameters:
PIX_W, 8, pixel width in bits
IMG_WIDTH, 8, pixels per row; must be even and >= 2
IMG_HEIGHT, 8, rows per frame; must be even and >= 2

Ports:
clk  input  1  single clock; all state on the rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  in_pixel is valid this cycle
in_ready  output  1  block can accept a pixel this cycle
in_pixel  input  PIX_W  raster-order pixel
out_valid  output  1  window outputs are valid
out_ready  input  1  downstream accepts the window
pixel_00  output  PIX_W  top-left (row 2r, col 2c)
pixel_01  output  PIX_W  top-right (row 2r, col 2c+1)
pixel_10  output  PIX_W  bottom-left (row 2r+1, col 2c)
pixel_11  output  PIX_W  bottom-right (row 2r+1, col 2c+1)
out_last  output  1  window is the last one of the frame

Behaviour:
- Reset, asynchronous on rst_n low:
  - out_valid=0, out_last=0, pixel_* = 0.
  - col=0, row=0, held-pixel register = 0.
  - Line-buffer contents are not reset. They are always written before being read.
- in_ready = !out_valid || out_ready (combinational). in_ready is 1 out of reset.
- An input beat is accepted when in_valid && in_ready. Only accepted beats advance col/row.
- Column counter:
  - col counts 0..IMG_WIDTH-1.
  - At IMG_WIDTH-1 it wraps to 0 and row increments.
- Row counter:
  - row counts 0..IMG_HEIGHT-1.
  - At IMG_HEIGHT-1 with col=IMG_WIDTH-1 it wraps to 0. The next frame follows seamlessly, with no idle cycle.
- Even row: accepted pixel is written to linebuf[col]. No output is produced.
- Odd row, even col: accepted pixel is stored in the held register. No output is produced.
- Odd row, odd col, on the next edge:
  - out_valid<=1, pixel_00<=linebuf[col-1], pixel_01<=linebuf[col], pixel_10<=held, pixel_11<=in_pixel.
  - out_last<=(row==IMG_HEIGHT-1 && col==IMG_WIDTH-1).
  - Latency: 1 cycle from the accepted bottom-right pixel to out_valid.
- Output hold:
  - While out_valid && !out_ready, all outputs hold stable and in_ready=0.
  - On out_valid && out_ready with no new window completing that cycle, out_valid<=0.
  - If a window is accepted and a new one completes in the same cycle, out_valid stays 1 and the new data loads. This gives full throughput.
- out_last is meaningful only while out_valid=1. It is cleared with out_valid.
- Reset mid-frame discards the partial frame. The first beat after reset is pixel (0,0).
- Pixel values pass through unmodified. No arithmetic is performed on data.

Optional Feature:
POOL_SOF_EN
- With the macro defined:
  - Adds input in_sof (1) and output sync_err (1, resets to 0).
  - An accepted beat with in_sof=1 forces that pixel to position (0,0) and continues counting from there.
  - If that beat arrives when (row,col) != (0,0), sync_err sets sticky until reset. Any partially built window is dropped; no output is produced for it.
- Without the macro: no such ports. Counters free-run purely by beat count.

Decomposition:
- Shared package pool_pkg:
  - PIX_W default constant.
  - Typedef pixel_t = logic [PIX_W-1:0].
  - Packed struct window_t {p00, p01, p10, p11}.
  - Position-type localparams: col/row widths derived via $clog2.
- One sub-module, pool_line_buffer:
  - IMG_WIDTH x PIX_W storage.
  - One synchronous write port and two combinational read ports (col-1, col).

Test Plan:
- Frame, no stall: 4x4 frame (IMG_WIDTH=IMG_HEIGHT=4), pixels 0..15, in_valid held 1, out_ready=1.
  - Expect windows (0,1,4,5), (2,3,6,7), (8,9,12,13), (10,11,14,15).
  - Each window appears 1 cycle after pixels 5, 7, 13, 15 respectively.
  - out_last=1 only on the 4th window.
- Backpressure: same stream with out_ready=0 for 3 cycles after the first window.
  - Window (0,1,4,5) holds stable and in_ready=0 for those cycles.
  - No pixel is lost; the remaining windows match the no-stall case.
- Extremes: pixels 8'hFF/8'h00 alternating in a 2x2 block.
  - Window outputs FF,00,00,FF exactly, with no width truncation.
- Reset mid-frame: assert rst_n=0 after pixel 9 of a 4x4 frame, then send a fresh frame 100..115.
  - out_valid=0 during reset.
  - First window is (100,101,104,105).
- Back-to-back frames: two 4x4 frames with no gap.
  - 8 windows total; out_last on the 4th and 8th.
  - The 5th window is (16,17,20,21) when the second frame uses pixels 16..31.
- POOL_SOF_EN: assert in_sof on pixel 6 of a frame.
  - sync_err=1.
  - The next windows are built treating pixel 6 as (0,0).
